// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD 7-segment display driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_seg_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-BCD nibbles (10..15) render as a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib,
  output logic [6:0]         seg
);

  // nibble to cathode pattern
  always_comb begin
    seg = SEG_DASH;
    unique case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Multiplexed 3-digit 7-segment driver with blank gap between digits.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_seg_display
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd,
  input  logic        rdy,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] shown
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0] I_LAST = 2'(NUM_DIGITS - 1);

  state_e      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] shown_q, shown_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        tick;
  logic [DIGIT_W-1:0] nib;
  logic [6:0]  dec_seg;
  logic        lz_blank;

  assign tick = (presc_q == P_LAST);

  // capture, prescaler and scan sequencing
  always_comb begin
    shown_d = rdy ? bcd : shown_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: state_d = ST_SHOW;
      ST_SHOW: begin
        if (tick) begin
          state_d = ST_BLANK;
          idx_d   = (idx_q == I_LAST) ? 2'd0 : idx_q + 2'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // pick the nibble for the active digit
  always_comb begin
    nib = shown_q[3:0];
    unique case (idx_q)
      2'd0:    nib = shown_q[3:0];
      2'd1:    nib = shown_q[7:4];
      default: nib = shown_q[11:8];
    endcase
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

`ifdef LEAD_ZERO_BLANK_EN
  // suppress leading zeros; ones digit always shows
  always_comb begin
    lz_blank = 1'b0;
    unique case (idx_q)
      2'd2:    lz_blank = (shown_q[11:8] == 4'd0);
      2'd1:    lz_blank = (shown_q[11:4] == 8'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  // all digits always decoded
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // registered cathode/anode drive; an[3] never enabled
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    if (state_q == ST_SHOW) begin
      an_d    = ~(4'b0001 << idx_q);
      an_d[3] = 1'b1;
      seg_d   = lz_blank ? SEG_BLANK : dec_seg;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      presc_q <= '0;
      idx_q   <= 2'd0;
      shown_q <= 12'h000;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign shown = shown_q;

endmodule
